// File: rtl/inert_sensor_serf_if.sv
// ============================================================================
// Module   : inert_sensor_serf_if
// Brief    : SPI pin bundle between the inertial-sensor monarch and serf.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inert_sensor_serf_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic INT;

  modport slave (
    input  SS_n,
    input  SCLK,
    input  MOSI,
    output MISO,
    output INT
  );

  modport master (
    output SS_n,
    output SCLK,
    output MOSI,
    input  MISO,
    input  INT
  );
endinterface

`default_nettype wire

// File: rtl/inert_sensor_serf.sv
// ============================================================================
// Module   : inert_sensor_serf
// Brief    : SPI serf model of a 6-axis inertial sensor with periodic samples.
//            Optional macro INERT_NOISE_EN adds LFSR noise to ax/ay.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inert_sensor_serf #(
  parameter int         ODR_PERIOD = 4096,
  parameter logic [7:0] WHO_AM_I   = 8'h6A
) (
  input wire clk,
  input wire rst_n,
  inert_sensor_serf_if.slave spi
);

  localparam int                c_ODR_W  = $clog2(ODR_PERIOD);
  localparam logic [c_ODR_W-1:0] c_ODR_TC = c_ODR_W'(ODR_PERIOD - 1);
  localparam logic [15:0]       c_AX     = 16'h0100;
  localparam logic [15:0]       c_AY     = 16'hFF00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_ss_meta, r_ss_sync, r_ss_prev;
  logic        r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic        r_mosi_meta, r_mosi_sync;
  logic [4:0]  r_bit_cnt;
  logic [7:0]  r_rx_sh, r_tx_sh, r_cmd;
  logic        r_miso;
  logic [7:0]  r_int_cfg, r_cfg10, r_cfg11, r_cfg14;
  logic        r_int, r_ovr, r_pend;
  logic [15:0] r_n, r_ptch, r_roll, r_yaw, r_ax, r_ay;
  logic [c_ODR_W-1:0] r_odr_cnt;

  logic        w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
  logic [7:0]  w_cmd, w_rd_byte;
  logic        w_frame_done, w_wr_commit, w_rd_done;
  logic        w_odr_tc, w_commit;
  logic [3:0]  w_noise;

  // Select chain resets to "selected" so a reset taken mid-frame cannot
  // manufacture a falling edge; the serf then waits for a genuine new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_meta   <= 1'b0;
      r_ss_sync   <= 1'b0;
      r_ss_prev   <= 1'b0;
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_ss_meta   <= spi.SS_n;
      r_ss_sync   <= r_ss_meta;
      r_ss_prev   <= r_ss_sync;
      r_sclk_meta <= spi.SCLK;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_mosi_meta <= spi.MOSI;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  assign w_ss_fall   =  r_ss_prev   & ~r_ss_sync;
  assign w_ss_rise   = ~r_ss_prev   &  r_ss_sync;
  assign w_sclk_rise =  r_sclk_sync & ~r_sclk_prev;
  assign w_sclk_fall = ~r_sclk_sync &  r_sclk_prev;
  assign w_cmd       = {r_rx_sh[6:0], r_mosi_sync};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: if (w_ss_fall) w_state_nxt = ST_CMD;
      ST_CMD: begin
        if (w_ss_rise)                               w_state_nxt = ST_IDLE;
        else if (w_sclk_rise && r_bit_cnt == 5'd7)   w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_ss_rise) begin
          w_state_nxt  = ST_IDLE;
          w_frame_done = (r_bit_cnt == 5'd16);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_wr_commit = w_frame_done & ~r_cmd[7];
  assign w_rd_done   = w_frame_done &  r_cmd[7];

  always_comb begin
    w_rd_byte = 8'h00;
    case (w_cmd[6:0])
      7'h0D: w_rd_byte = r_int_cfg;
      7'h0F: w_rd_byte = WHO_AM_I;
      7'h10: w_rd_byte = r_cfg10;
      7'h11: w_rd_byte = r_cfg11;
      7'h14: w_rd_byte = r_cfg14;
      7'h1E: w_rd_byte = {6'b0, r_ovr, r_int};
      7'h22: w_rd_byte = r_ptch[7:0];
      7'h23: w_rd_byte = r_ptch[15:8];
      7'h24: w_rd_byte = r_roll[7:0];
      7'h25: w_rd_byte = r_roll[15:8];
      7'h26: w_rd_byte = r_yaw[7:0];
      7'h27: w_rd_byte = r_yaw[15:8];
      7'h28: w_rd_byte = r_ax[7:0];
      7'h29: w_rd_byte = r_ax[15:8];
      7'h2A: w_rd_byte = r_ay[7:0];
      7'h2B: w_rd_byte = r_ay[15:8];
      default: w_rd_byte = 8'h00;
    endcase
  end

  // Read byte is captured on the 8th rising edge, ahead of the falling edge
  // that presents its MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= 5'd0;
      r_rx_sh   <= 8'h00;
      r_tx_sh   <= 8'h00;
      r_cmd     <= 8'h00;
      r_miso    <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_miso <= 1'b0;
      if (w_ss_fall) begin
        r_bit_cnt <= 5'd0;
        r_rx_sh   <= 8'h00;
        r_tx_sh   <= 8'h00;
      end
    end else if (w_sclk_rise) begin
      r_rx_sh <= w_cmd;
      if (r_bit_cnt != 5'd31) r_bit_cnt <= r_bit_cnt + 5'd1;
      if (r_state == ST_CMD && r_bit_cnt == 5'd7) begin
        r_cmd   <= w_cmd;
        r_tx_sh <= w_cmd[7] ? w_rd_byte : 8'h00;
      end
    end else if (w_sclk_fall && r_state == ST_DATA) begin
      r_miso  <= r_tx_sh[7];
      r_tx_sh <= {r_tx_sh[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_cfg <= 8'h00;
      r_cfg10   <= 8'h00;
      r_cfg11   <= 8'h00;
      r_cfg14   <= 8'h00;
    end else if (w_wr_commit) begin
      case (r_cmd[6:0])
        7'h0D: r_int_cfg <= r_rx_sh;
        7'h10: r_cfg10   <= r_rx_sh;
        7'h11: r_cfg11   <= r_rx_sh;
        7'h14: r_cfg14   <= r_rx_sh;
        default: ;
      endcase
    end
  end

  assign w_odr_tc = r_int_cfg[1] && (r_odr_cnt == c_ODR_TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_odr_cnt <= '0;
    else if (!r_int_cfg[1] || w_odr_tc) r_odr_cnt <= '0;
    else                                r_odr_cnt <= r_odr_cnt + c_ODR_W'(1);
  end

  // Samples land in the data registers only between frames so a read never
  // straddles two samples.
  assign w_commit = r_pend && (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n    <= 16'h0000;
      r_pend <= 1'b0;
    end else if (w_odr_tc) begin
      r_n    <= r_n + 16'd1;
      r_pend <= 1'b1;
    end else if (w_commit) begin
      r_pend <= 1'b0;
    end
  end

`ifdef INERT_NOISE_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;

  assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_noise    = w_lfsr_nxt[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_lfsr <= 16'hACE1;
    else if (w_commit) r_lfsr <= w_lfsr_nxt;
  end
`else
  assign w_noise = 4'h0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptch <= 16'h0000;
      r_roll <= 16'h0000;
      r_yaw  <= 16'h0000;
      r_ax   <= c_AX;
      r_ay   <= c_AY;
    end else if (w_commit) begin
      r_ptch <= r_n;
      r_roll <= 16'h0000 - r_n;
      r_yaw  <= {r_n[14:0], 1'b0};
      r_ax   <= c_AX ^ {12'h000, w_noise};
      r_ay   <= c_AY ^ {12'h000, w_noise};
    end
  end

  // A commit outranks a same-cycle clear for both INT and overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (w_commit)                                 r_int <= 1'b1;
      else if (w_rd_done && r_cmd[6:0] == 7'h22)    r_int <= 1'b0;
      if (w_commit && r_int)                        r_ovr <= 1'b1;
      else if (w_rd_done && r_cmd[6:0] == 7'h1E)    r_ovr <= 1'b0;
    end
  end

  assign spi.MISO = r_miso;
  assign spi.INT  = r_int;

endmodule

`default_nettype wire

// File: tb/tb_inert_sensor_serf.sv
// ============================================================================
// Module   : tb_inert_sensor_serf
// Brief    : Self-checking bench for inert_sensor_serf (scoreboarded SPI reads).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_inert_sensor_serf;

  localparam int c_ODR  = 2048;
  localparam int c_HALF = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  inert_sensor_serf_if spi_if ();

  inert_sensor_serf #(
    .ODR_PERIOD (c_ODR),
    .WHO_AM_I   (8'h6A)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .spi   (spi_if.slave)
  );

  always #10 clk = ~clk;

  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] exp_q[$];
  logic       int_pre_ss = 1'b0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 monarch; rst_at < nbits pulses rst_n before that bit.
  task automatic spi_xfer(input logic [15:0] frm, input int nbits, input int rst_at,
                          output logic [7:0] b0, output logic [7:0] b1);
    logic [15:0] cap;
    cap = 16'h0000;
    spi_if.SS_n = 1'b0;
    tick(c_HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(2);
      end
      spi_if.MOSI = frm[15-i];
      tick(c_HALF);
      cap[15-i] = spi_if.MISO;
      spi_if.SCLK = 1'b1;
      tick(c_HALF);
      spi_if.SCLK = 1'b0;
    end
    tick(c_HALF);
    int_pre_ss  = spi_if.INT;
    spi_if.SS_n = 1'b1;
    spi_if.MOSI = 1'b0;
    tick(16);
    b0 = cap[15:8];
    b1 = cap[7:0];
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [7:0] dat, input logic [7:0] exp);
    logic [7:0] b0, b1;
    exp_q.push_back(exp);
    spi_xfer({cmd, dat}, 16, -1, b0, b1);
    check($sformatf("miso_b0_%02h", cmd), b0, 8'h00);
    check($sformatf("miso_b1_%02h", cmd), b1, exp_q.pop_front());
  endtask

  task automatic wr(input logic [6:0] addr, input logic [7:0] dat);
    frame({1'b0, addr}, dat, 8'h00);
  endtask

  task automatic rd(input logic [6:0] addr, input logic [7:0] exp);
    frame({1'b1, addr}, 8'h00, exp);
  endtask

  task automatic wait_int(input int bound, input string tag);
    int k;
    k = 0;
    while (spi_if.INT !== 1'b1 && k < bound) begin
      tick(1);
      k++;
    end
    check(tag, 8'(spi_if.INT), 8'h01);
  endtask

  initial begin
    logic [7:0] b0, b1;
    spi_if.SS_n = 1'b1;
    spi_if.SCLK = 1'b0;
    spi_if.MOSI = 1'b0;
    tick(5);
    check("miso_in_rst", 8'(spi_if.MISO), 8'h00);
    check("int_in_rst",  8'(spi_if.INT),  8'h00);
    rst_n = 1'b1;
    tick(8);
    check("miso_idle", 8'(spi_if.MISO), 8'h00);

    // Config write/read and identity
    wr(7'h0D, 8'h02);
    rd(7'h0D, 8'h02);
    rd(7'h0F, 8'h6A);

    // First sample
    wait_int(2 * c_ODR, "int_s1");
    rd(7'h22, 8'h01);
    check("int_clr_s1", 8'(spi_if.INT), 8'h00);
    rd(7'h23, 8'h00);
    wr(7'h0D, 8'h00);

    // Samples two and three
    wr(7'h0D, 8'h02);
    wait_int(2 * c_ODR, "int_s2");
    rd(7'h22, 8'h02);
    check("int_clr_s2", 8'(spi_if.INT), 8'h00);
    wait_int(2 * c_ODR, "int_s3");
    wr(7'h0D, 8'h00);
    rd(7'h24, 8'hFD);
    rd(7'h25, 8'hFF);
    rd(7'h26, 8'h06);
    rd(7'h27, 8'h00);
    rd(7'h28, 8'h00);
    rd(7'h29, 8'h01);
    rd(7'h2A, 8'h00);
    rd(7'h2B, 8'hFF);

    // Two unread samples -> overrun
    wr(7'h0D, 8'h02);
    tick(2 * c_ODR + 600);
    wr(7'h0D, 8'h00);
    rd(7'h1E, 8'h03);
    rd(7'h1E, 8'h01);

    // Frame straddling terminal count keeps the old sample
    rd(7'h22, 8'h05);
    check("int_clr_s5", 8'(spi_if.INT), 8'h00);
    wr(7'h0D, 8'h02);
    tick(c_ODR - 150);
    rd(7'h22, 8'h05);
    check("int_held_in_frame", 8'(int_pre_ss), 8'h00);
    wait_int(64, "int_after_frame");
    wr(7'h0D, 8'h00);
    rd(7'h22, 8'h06);
    check("int_clr_s6", 8'(spi_if.INT), 8'h00);

    // Short frame and reset mid-frame
    spi_xfer(16'h1055, 10, -1, b0, b1);
    rd(7'h10, 8'h00);
    spi_xfer(16'h1055, 16, 12, b0, b1);
    check("int_after_mrst",  8'(spi_if.INT),  8'h00);
    check("miso_after_mrst", 8'(spi_if.MISO), 8'h00);
    rd(7'h10, 8'h00);
    rd(7'h0F, 8'h6A);
    rd(7'h22, 8'h00);
    rd(7'h0D, 8'h00);

    // Storage, RO and unmapped behaviour
    wr(7'h10, 8'h55);
    wr(7'h11, 8'hA3);
    wr(7'h14, 8'h3C);
    wr(7'h0F, 8'h12);
    wr(7'h30, 8'hAA);
    rd(7'h10, 8'h55);
    rd(7'h11, 8'hA3);
    rd(7'h14, 8'h3C);
    rd(7'h0F, 8'h6A);
    rd(7'h30, 8'h00);
    check("miso_idle_end", 8'(spi_if.MISO), 8'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
